// File: rtl/vend_payout_ctrl.sv
// Payout sequencer: queues vend/change events and plays them out as soda, dimes, then nickels
// over req/ack handshakes. Optional request timeout with sticky fault: VEND_PAYOUT_TIMEOUT_EN.
module vend_payout_ctrl #(
  parameter int DEPTH       = 2,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     soda_i,
  input  logic [2:0]               change_i,
  output logic                     soda_req_o,
  input  logic                     soda_ack_i,
  output logic                     dime_req_o,
  output logic                     nickel_req_o,
  input  logic                     coin_ack_i,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   pending_o,
  output logic                     drop_o,
  output logic                     fault_o
);
  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("vend_payout_ctrl: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [2:0] {IDLE, VEND, PAY, GAP, FAULT} state_t;
  state_t state;

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [2:0]    remaining;
  logic [2:0]    rem_after;
  logic [3:0]    head;
  logic          event_in;
  logic          full;
  logic          pop;
  logic          push;
  logic          timeout;

  assign event_in  = soda_i || (change_i != 3'd0);
  assign full      = (count == (AW + 1)'(DEPTH));
  assign pop       = (state == IDLE) && (count != '0);
  // A full queue still accepts when the head leaves on the same edge.
  assign push      = event_in && (!full || pop);
  assign head      = mem[rd_ptr];
  assign rem_after = remaining - (dime_req_o ? 3'd2 : 3'd1);
  assign busy_o    = (state != IDLE) || (count != '0);
  assign pending_o = count;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {soda_i, change_i};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      drop_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      drop_o <= event_in && !push;
    end
  end

`ifdef VEND_PAYOUT_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  logic [TCW-1:0] tcnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                                tcnt <= '0;
    else if (state == VEND || state == PAY)     tcnt <= tcnt + TCW'(1);
    else                                        tcnt <= '0;
  end

  // Fires during the last permitted waiting cycle so the request is high exactly TIMEOUT_CYC cycles.
  assign timeout = (tcnt == TCW'(TIMEOUT_CYC - 1)) &&
                   ((state == VEND && !soda_ack_i) || (state == PAY && !coin_ack_i));
  assign fault_o = (state == FAULT);
`else
  assign timeout = 1'b0;
  assign fault_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= IDLE;
      remaining    <= '0;
      soda_req_o   <= 1'b0;
      dime_req_o   <= 1'b0;
      nickel_req_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            remaining <= head[2:0];
            if (head[3]) begin
              state      <= VEND;
              soda_req_o <= 1'b1;
            end else if (head[2:0] != 3'd0) begin
              state        <= PAY;
              dime_req_o   <= (head[2:0] >= 3'd2);
              nickel_req_o <= (head[2:0] == 3'd1);
            end
          end
        end
        VEND: begin
          if (soda_ack_i) begin
            soda_req_o <= 1'b0;
            state      <= (remaining != 3'd0) ? GAP : IDLE;
          end else if (timeout) begin
            soda_req_o <= 1'b0;
            state      <= FAULT;
          end
        end
        PAY: begin
          if (coin_ack_i) begin
            dime_req_o   <= 1'b0;
            nickel_req_o <= 1'b0;
            remaining    <= rem_after;
            state        <= (rem_after != 3'd0) ? GAP : IDLE;
          end else if (timeout) begin
            dime_req_o   <= 1'b0;
            nickel_req_o <= 1'b0;
            state        <= FAULT;
          end
        end
        GAP: begin
          // Coin type is chosen here and held until the hopper acks.
          state        <= PAY;
          dime_req_o   <= (remaining >= 3'd2);
          nickel_req_o <= (remaining == 3'd1);
        end
        FAULT: state <= FAULT;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vend_payout_ctrl.sv
// Self-checking bench for vend_payout_ctrl: directed scenarios plus randomized bursts
// against a queue-of-coins reference model.
module tb_vend_payout_ctrl;
  localparam int DEPTH = 2;
  localparam int TO    = 10;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          soda_i = 1'b0;
  logic [2:0]    change_i = 3'd0;
  logic          soda_ack_i;
  logic          coin_ack_i;
  logic          soda_req_o;
  logic          dime_req_o;
  logic          nickel_req_o;
  logic          busy_o;
  logic [PW-1:0] pending_o;
  logic          drop_o;
  logic          fault_o;

  logic auto_soda = 1'b0;
  logic auto_coin = 1'b0;
  logic man_soda  = 1'b0;
  assign soda_ack_i = auto_soda | man_soda;
  assign coin_ack_i = auto_coin;

  vend_payout_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .soda_i(soda_i), .change_i(change_i),
    .soda_req_o(soda_req_o), .soda_ack_i(soda_ack_i), .dime_req_o(dime_req_o),
    .nickel_req_o(nickel_req_o), .coin_ack_i(coin_ack_i), .busy_o(busy_o),
    .pending_o(pending_o), .drop_o(drop_o), .fault_o(fault_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int got[$];
  int exp_q[$];
  int drop_cnt = 0;
  bit ack_en = 1'b0;
  bit spur = 1'b0;
  int fixed_dly = 0;
  logic [2:0] prev_req = 3'd0;
  int sa = 0, ca = 0, sd = 1, cd = 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, req);
    end
  endtask

  // Reference: soda first, then as many dimes as fit, then a nickel for an odd remainder.
  function automatic void expand(input bit s, input int c);
    if (s) exp_q.push_back(1);
    for (int i = 0; i < c / 2; i++) exp_q.push_back(2);
    if (c % 2 == 1) exp_q.push_back(3);
  endfunction

  task automatic compare_tokens(input string tag);
    int n;
    check({tag, "_count"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_order"}, got[i], exp_q[i]);
    $display("[TB] %s: %0d requests observed", tag, got.size());
    got.delete();
    exp_q.delete();
  endtask

  task automatic ev(input bit s, input logic [2:0] c);
    soda_i = s;
    change_i = c;
    @(negedge clk_i);
    soda_i = 1'b0;
    change_i = 3'd0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (!busy_o && !soda_req_o && !dime_req_o && !nickel_req_o) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_idle"}, ok, 1);
  endtask

  task automatic wait_req(input bit dime, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if ((!dime && soda_req_o) || (dime && dime_req_o)) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_req_seen"}, ok, 1);
  endtask

  // Monitor: records each request as it rises, checks exclusivity, counts drop pulses.
  initial begin
    logic [2:0] cur;
    forever begin
      @(negedge clk_i);
      cur = {soda_req_o, dime_req_o, nickel_req_o};
      check("onehot_req", ($countones(cur) <= 1), 1);
      if (cur != 3'd0 && prev_req == 3'd0) got.push_back(cur[2] ? 1 : (cur[1] ? 2 : 3));
      if (drop_o) drop_cnt++;
      prev_req = cur;
    end
  end

  // Actuator model: acks after a delay, plus optional stray acks while the matching request is low.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      auto_soda = 1'b0;
      auto_coin = 1'b0;
      if (soda_req_o && ack_en) sa++;
      else begin
        sa = 0;
        sd = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 4));
      end
      if (sa != 0 && sa == sd) auto_soda = 1'b1;
      if ((dime_req_o || nickel_req_o) && ack_en) ca++;
      else begin
        ca = 0;
        cd = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 4));
      end
      if (ca != 0 && ca == cd) auto_coin = 1'b1;
      if (spur && !soda_req_o && $urandom_range(0, 3) == 0) auto_soda = 1'b1;
      if (spur && !dime_req_o && !nickel_req_o && $urandom_range(0, 3) == 0) auto_coin = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, hc, nb, s, c;
    repeat (3) @(negedge clk_i);
    check("rst_outs", {soda_req_o, dime_req_o, nickel_req_o, busy_o, drop_o, fault_o}, 0);
    check("rst_pending", pending_o, 0);
    reset_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_busy", busy_o, 0);

    // Vend plus 15 cents, acks on the third request cycle.
    ack_en = 1'b1;
    fixed_dly = 3;
    expand(1, 3);
    ev(1'b1, 3'd3);
    check("lat_cycle1", soda_req_o, 0);
    @(negedge clk_i);
    check("lat_cycle2", soda_req_o, 1);
    wait_idle(100, "vend3");
    check("vend3_busy", busy_o, 0);
    compare_tokens("vend3");

    // Largest change value.
    expand(0, 7);
    ev(1'b0, 3'd7);
    wait_idle(200, "chg7");
    check("chg7_pending", pending_o, 0);
    compare_tokens("chg7");

    // Queue overflow while the soda motor never acks.
    ack_en = 1'b0;
    fixed_dly = 0;
    d0 = drop_cnt;
    expand(1, 0);
    expand(0, 1);
    expand(0, 2);
    ev(1'b1, 3'd0);
    ev(1'b0, 3'd1);
    ev(1'b0, 3'd2);
    ev(1'b1, 3'd3);
    check("full_pending", pending_o, 2);
    repeat (2) @(negedge clk_i);
    check("full_drop", drop_cnt - d0, 1);
    check("full_soda_held", soda_req_o, 1);

    // Ack the soda, then push into the full queue on the cycle the head is popped.
    man_soda = 1'b1;
    @(negedge clk_i);
    man_soda = 1'b0;
    check("pp_req_low", soda_req_o, 0);
    expand(0, 2);
    ev(1'b0, 3'd2);
    check("pp_pending", pending_o, 2);
    repeat (2) @(negedge clk_i);
    check("pp_no_drop", drop_cnt - d0, 1);
    ack_en = 1'b1;
    wait_idle(200, "full");
    check("full_pending_end", pending_o, 0);
    compare_tokens("full");

    // Reset while a dime is requested and another event waits.
    ack_en = 1'b0;
    ev(1'b0, 3'd4);
    ev(1'b1, 3'd0);
    wait_req(1'b1, "mid_rst");
    check("mid_rst_queued", pending_o, 1);
    #2 reset_i = 1'b1;
    #1;
    check("mid_rst_outs", {soda_req_o, dime_req_o, nickel_req_o, busy_o, drop_o, fault_o}, 0);
    check("mid_rst_pending", pending_o, 0);
    @(negedge clk_i);
    reset_i = 1'b0;
    got.delete();
    exp_q.delete();
    ack_en = 1'b1;
    repeat (20) @(negedge clk_i);
    check("mid_rst_no_req", got.size(), 0);
    check("mid_rst_busy", busy_o, 0);

    // Withheld soda ack.
    ack_en = 1'b0;
    expand(1, 0);
    ev(1'b1, 3'd0);
    wait_req(1'b0, "to");
    hc = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i);
      if (soda_req_o) hc++;
      else break;
    end
`ifdef VEND_PAYOUT_TIMEOUT_EN
    check("to_high_cycles", hc, TO);
    check("to_fault", fault_o, 1);
    man_soda = 1'b1;
    @(negedge clk_i);
    man_soda = 1'b0;
    repeat (3) @(negedge clk_i);
    check("to_fault_sticky", fault_o, 1);
    check("to_reqs_low", {soda_req_o, dime_req_o, nickel_req_o}, 0);
    ev(1'b0, 3'd1);
    check("to_fault_push", pending_o, 1);
    compare_tokens("to");
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    check("to_fault_cleared", fault_o, 0);
    check("to_pending_cleared", pending_o, 0);
`else
    check("to_high_cycles", hc, 61);
    check("to_no_fault", fault_o, 0);
    ack_en = 1'b1;
    wait_idle(50, "to");
    compare_tokens("to");
`endif

    // Random bursts of 1..3 events from idle, random ack delays and stray acks.
    ack_en = 1'b1;
    spur = 1'b1;
    fixed_dly = 0;
    d0 = drop_cnt;
    for (int it = 0; it < 30; it++) begin
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) begin
        s = $urandom_range(0, 1);
        c = $urandom_range(0, 7);
        if (s == 0 && c == 0) c = $urandom_range(1, 7);
        expand(s[0], c);
        ev(s[0], c[2:0]);
      end
      wait_idle(400, "rnd");
    end
    spur = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rnd_drops", drop_cnt - d0, 0);
    check("rnd_pending", pending_o, 0);
    compare_tokens("rnd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vend_payout_ctrl.md
Name: vend_payout_ctrl

Overview:
- Payout sequencer behind the vending machine core.
- Captures each vend/change event from the core (soda pulse plus change code in nickels) into a small queue.
- Dispenses each event in order: soda motor first, then change as dimes-first coins to a coin hopper. Every actuator uses a req/ack handshake.
- Decouples the single-cycle core outputs from slow mechanical actuators.

Parameters:
- DEPTH, 2, event queue entries (power of 2, >=2)
- TIMEOUT_CYC, 1000, max cycles a request may wait for ack (used only with the optional feature)

Ports:
- clk_i  in  1  clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- soda_i  in  1  one-cycle vend pulse from core
- change_i  in  3  change owed in nickels (0..7 = 0..35 cents), valid in the same cycle as the event
- soda_req_o  out  1  soda motor request, held until ack
- soda_ack_i  in  1  soda motor done
- dime_req_o  out  1  hopper: eject one dime, held until ack
- nickel_req_o  out  1  hopper: eject one nickel, held until ack
- coin_ack_i  in  1  hopper done (one coin)
- busy_o  out  1  FSM not IDLE or queue non-empty
- pending_o  out  $clog2(DEPTH)+1  queue occupancy
- drop_o  out  1  one-cycle pulse: event lost, queue full
- fault_o  out  1  sticky timeout fault (0 without the feature)

Behaviour:
- Reset (async): queue empty, FSM=IDLE, remaining=0. All outputs 0.
- Event definition: soda_i=1 or change_i!=0 in a cycle. Each event is pushed as {soda_i, change_i} at that edge.
- Push rule: accepted if queue not full, or if a pop occurs in the same cycle. Otherwise the event is discarded and drop_o=1 for one cycle.
- FSM states: IDLE, VEND, PAY, GAP, FAULT.
- IDLE: if queue non-empty, pop and load remaining=change.
  - Soda bit set -> VEND.
  - Soda bit clear and remaining!=0 -> PAY.
  - An entry cannot have both soda=0 and change=0.
- VEND: soda_req_o=1 (registered). On edge with soda_ack_i=1: req drops, remaining!=0 -> GAP, else -> IDLE.
- PAY:
  - remaining>=2 -> dime_req_o=1; remaining==1 -> nickel_req_o=1.
  - Coin type is fixed at PAY entry and never changes while the request is held.
  - On coin_ack_i=1: remaining -= 2 (dime) or 1 (nickel). Then -> GAP if new remaining!=0, else -> IDLE.
- GAP: one cycle with all requests low, then -> PAY. This gives the mandatory one-cycle deassert between consecutive requests.
- At most one request output is high in any cycle.
- Acks arriving while the matching request is low are ignored. soda_ack_i is ignored in PAY and coin_ack_i in VEND.
- Latency: event in cycle N -> first request high in cycle N+2 when the FSM was idle with an empty queue.
- IDLE pops the next entry on the cycle it re-enters IDLE, so back-to-back events leave one IDLE cycle between transactions.
- pending_o updates on the push/pop edge. A simultaneous push and pop leaves it unchanged.
- busy_o is combinational from state and occupancy.
- Reset mid-transaction: requests drop immediately (async) and the queued events are lost.

Optional Feature:
- Macro: VEND_PAYOUT_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to VEND/PAY and increments each cycle a request is high without ack.
  - When the count reaches TIMEOUT_CYC: all requests drop, FSM -> FAULT, fault_o=1.
  - FAULT is left only by reset. Pushes continue to fill the queue (drop_o when full); no pops occur.
- Not defined: no counter or FAULT state. fault_o is tied 0 and requests wait for ack indefinitely.

Test Plan:
- Vend with change: soda_i=1, change_i=3 in cycle 0; acks returned 3 cycles after each request.
  - Required: soda_req high cycles 2..; then dime_req, then nickel_req, each separated by one low cycle.
  - Required: exactly 2 coin requests total; busy_o low after final ack.
- Max change: change_i=7, soda_i=0 -> dime, dime, dime, nickel (4 requests). nickel_req_o never high alongside dime_req_o. pending_o returns to 0.
- Queue full (DEPTH=2, acks withheld): 4 events in consecutive cycles.
  - First event popped; events 2 and 3 queued, pending_o=2; event 4 gives drop_o pulse.
  - After acks: exactly 3 transactions complete, in order.
- Push+pop same cycle with queue full: event accepted, no drop_o, pending_o unchanged.
- Mid-operation reset: assert reset_i while dime_req_o=1 with a queued entry.
  - All outputs 0 immediately; pending_o=0; no request after release.
- With VEND_PAYOUT_TIMEOUT_EN, TIMEOUT_CYC=10: withhold soda_ack_i.
  - soda_req_o drops after 10 cycles high; fault_o=1 and stays until reset; later acks ignored.
  - Without the macro: the request stays high indefinitely and fault_o=0.
